dm_1k: RTL and testbench



---
 rtl/dm_1k.sv | 58 +++++
 tb/tb_dm_1k.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dm_1k.sv
// 1 KiB byte-addressed data memory for the single-cycle MIPS datapath.
// Word and byte accesses, little-endian, modulo-1024 addressing, combinational read.
`ifndef DM_WORD
`define DM_WORD 1'b0
`endif
`ifndef DM_BYTE
`define DM_BYTE 1'b1
`endif

module dm_1k (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  addr,
  input  logic [31:0] din,
  input  logic        WriteEn,
  input  logic        sel,
  output logic [31:0] dout
);

  logic [7:0] mem [1024];

  // 10-bit sums wrap modulo 1024 on their own, so unaligned words at the top wrap to 0.
  logic [9:0] addr_1;
  logic [9:0] addr_2;
  logic [9:0] addr_3;

  assign addr_1 = addr + 10'd1;
  assign addr_2 = addr + 10'd2;
  assign addr_3 = addr + 10'd3;

  // NOTE: the whole array is cleared by the async reset, so it is built from
  // resettable flops rather than a RAM macro; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (WriteEn) begin
      mem[addr] <= din[7:0];
      if (sel == `DM_WORD) begin
        mem[addr_1] <= din[15:8];
        mem[addr_2] <= din[23:16];
        mem[addr_3] <= din[31:24];
      end
    end
  end

  // NOTE: every output of this combinational block gets a default first, so no latch is inferred.
  always_comb begin
    dout = 32'h0000_0000;
    if (sel == `DM_BYTE) begin
      dout = {{24{mem[addr][7]}}, mem[addr]};
    end else begin
      dout = {mem[addr_3], mem[addr_2], mem[addr_1], mem[addr]};
    end
  end

endmodule

// File: tb/tb_dm_1k.sv
// Self-checking bench for dm_1k: directed corner cases plus random traffic
// compared against a byte-array reference model.
module tb_dm_1k;

  localparam logic SEL_WORD = 1'b0;
  localparam logic SEL_BYTE = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;
  logic        write_en = 1'b0;
  logic        sel = SEL_WORD;
  logic [31:0] dout;

  always #5 clk = ~clk;

  dm_1k dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .din     (din),
    .WriteEn (write_en),
    .sel     (sel),
    .dout    (dout)
  );

  logic [7:0] ref_mem [1024];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int a, input logic s);
    logic [7:0]  b;
    logic [31:0] w;
    if (s == SEL_BYTE) begin
      b = ref_mem[a % 1024];
      return b[7] ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
    end
    w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(ref_mem[(a + k) % 1024]) << (8 * k));
    return w;
  endfunction

  task automatic model_write(input int a, input logic s, input logic [31:0] d);
    if (s == SEL_BYTE) ref_mem[a % 1024] = d[7:0];
    else for (int k = 0; k < 4; k++) ref_mem[(a + k) % 1024] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  // One full clock: drive after the falling edge, check old contents before the
  // rising edge, then check the (possibly) updated contents just after it.
  task automatic cycle(input logic we, input logic s, input logic [9:0] a,
                       input logic [31:0] d, input string tag);
    @(negedge clk);
    write_en = we; sel = s; addr = a; din = d;
    #1 check({tag, "_pre"}, dout, model_read(int'(a), s));
    @(posedge clk);
    if (we && rst_n) model_write(int'(a), s, d);
    #1 check({tag, "_post"}, dout, model_read(int'(a), s));
  endtask

  task automatic read_chk(input logic s, input logic [9:0] a,
                          input logic [31:0] exp, input string tag);
    @(negedge clk);
    write_en = 1'b0; sel = s; addr = a; din = 32'hDEAD_0000;
    #1 check(tag, dout, exp);
  endtask

  initial begin
    model_clear();

    // Reset held: output zero regardless of address.
    addr = 10'd5; sel = SEL_WORD;
    #2 check("rst_word_5", dout, 32'h0);
    addr = 10'd1023; sel = SEL_BYTE;
    #1 check("rst_byte_1023", dout, 32'h0);
    #9 rst_n = 1'b1;

    read_chk(SEL_WORD, 10'd1000, 32'h0, "post_rst_word");
    read_chk(SEL_BYTE, 10'd77,   32'h0, "post_rst_byte");

    cycle(1'b1, SEL_WORD, 10'd0, 32'h1234_5678, "wr_word0");
    read_chk(SEL_WORD, 10'd0, 32'h1234_5678, "rd_word0");
    read_chk(SEL_BYTE, 10'd0, 32'h0000_0078, "rd_byte0");
    read_chk(SEL_BYTE, 10'd1, 32'h0000_0056, "rd_byte1");
    read_chk(SEL_BYTE, 10'd2, 32'h0000_0034, "rd_byte2");
    read_chk(SEL_BYTE, 10'd3, 32'h0000_0012, "rd_byte3");

    cycle(1'b0, SEL_WORD, 10'd1, 32'h0, "no_write");
    read_chk(SEL_WORD, 10'd1, 32'h0012_3456, "rd_unaligned1");

    cycle(1'b1, SEL_BYTE, 10'd0, 32'h0000_0087, "wr_byte0");
    read_chk(SEL_BYTE, 10'd0, 32'hFFFF_FF87, "rd_byte0_sext");
    read_chk(SEL_WORD, 10'd0, 32'h1234_5687, "rd_word0_merge");

    cycle(1'b1, SEL_BYTE, 10'd2, 32'hFFFF_FF00, "wr_byte_hi_ignored");
    read_chk(SEL_WORD, 10'd0, 32'h1200_5687, "rd_word0_byte2");

    cycle(1'b1, SEL_WORD, 10'd1022, 32'hAABB_CCDD, "wr_wrap");
    read_chk(SEL_WORD, 10'd1022, 32'hAABB_CCDD, "rd_wrap_word");
    read_chk(SEL_BYTE, 10'd0,    32'hFFFF_FFBB, "rd_wrap_byte0");
    read_chk(SEL_BYTE, 10'd1,    32'hFFFF_FFAA, "rd_wrap_byte1");

    // Random traffic, with a bias toward the top of the address space.
    for (int i = 0; i < 400; i++) begin
      logic       we;
      logic       s;
      logic [9:0] a;
      we = ($urandom_range(0, 1) == 1);
      s  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom);
      cycle(we, s, a, $urandom, "rand");
    end
    for (int i = 0; i < 40; i++) begin
      logic [9:0] a;
      logic       s;
      a = 10'($urandom);
      s = 1'($urandom_range(0, 1));
      read_chk(s, a, model_read(int'(a), s), "rand_rd");
    end

    // Mid-cycle asynchronous reset clears without a clock edge.
    cycle(1'b1, SEL_WORD, 10'd500, 32'hDEAD_BEEF, "wr_before_rst");
    @(negedge clk);
    write_en = 1'b0; sel = SEL_WORD; addr = 10'd500;
    #1 check("pre_async_rst", dout, 32'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    model_clear();
    #1 check("async_rst_clear", dout, 32'h0);

    cycle(1'b1, SEL_WORD, 10'd500, 32'hFFFF_FFFF, "wr_during_rst");
    read_chk(SEL_WORD, 10'd500, 32'h0, "rd_after_wr_in_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    read_chk(SEL_WORD, 10'd0,    32'h0, "rel_word0");
    read_chk(SEL_WORD, 10'd1022, 32'h0, "rel_word1022");
    read_chk(SEL_BYTE, 10'd1,    32'h0, "rel_byte1");

    cycle(1'b1, SEL_WORD, 10'd500, 32'h0BAD_F00D, "first_wr_after_rel");
    read_chk(SEL_WORD, 10'd500, 32'h0BAD_F00D, "rd_first_wr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
